// File: rtl/spi_master_core.sv
// Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, with a
// programmable SCLK half-period. All outputs are registered.
module spi_master_core #(
  parameter int unsigned DEFAULT_CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  tx_data,
  input  logic [15:0] clk_div_in,
  output logic [7:0]  rx_data,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        irq,
  input  logic        miso,
  output logic        mosi,
  output logic        sclk,
  output logic        cs
);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] div, div_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic [7:0]  rx_data_n;
  logic        ready_n, busy_n, done_n, irq_n, mosi_n, sclk_n, cs_n;
  logic        half_done;

  always_comb begin
    half_done = (cnt == div - 16'd1);
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    div_n     = div;
    bit_cnt_n = bit_cnt;
    tx_sh_n   = tx_sh;
    rx_sh_n   = rx_sh;
    rx_data_n = rx_data;
    ready_n   = ready;
    busy_n    = busy;
    done_n    = 1'b0;
    irq_n     = irq;
    mosi_n    = mosi;
    sclk_n    = sclk;
    cs_n      = cs;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          tx_sh_n   = tx_data;
          div_n     = (clk_div_in == 16'd0) ? 16'(DEFAULT_CLK_DIV) : clk_div_in;
          bit_cnt_n = '0;
          cs_n      = 1'b0;
          mosi_n    = tx_data[7];
          busy_n    = 1'b1;
          ready_n   = 1'b0;
          irq_n     = 1'b0;
          state_n   = LEAD;
        end
      end
      LEAD: begin
        // First rising edge also samples MISO, so bit 7 is captured here.
        if (half_done) begin
          cnt_n   = '0;
          sclk_n  = 1'b1;
          rx_sh_n = {rx_sh[6:0], miso};
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (half_done) begin
          cnt_n = '0;
          if (sclk) begin
            sclk_n = 1'b0;
            if (bit_cnt == 3'd7) begin
              state_n = TRAIL;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
              tx_sh_n   = {tx_sh[6:0], 1'b0};
              mosi_n    = tx_sh[6];
            end
          end else begin
            sclk_n  = 1'b1;
            rx_sh_n = {rx_sh[6:0], miso};
          end
        end
      end
      TRAIL: begin
        if (half_done) begin
          cnt_n     = '0;
          cs_n      = 1'b1;
          rx_data_n = rx_sh;
          done_n    = 1'b1;
          irq_n     = 1'b1;
          busy_n    = 1'b0;
          ready_n   = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      div     <= 16'(DEFAULT_CLK_DIV);
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      irq     <= 1'b0;
      mosi    <= 1'b0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div     <= div_n;
      bit_cnt <= bit_cnt_n;
      tx_sh   <= tx_sh_n;
      rx_sh   <= rx_sh_n;
      rx_data <= rx_data_n;
      ready   <= ready_n;
      busy    <= busy_n;
      done    <= done_n;
      irq     <= irq_n;
      mosi    <= mosi_n;
      sclk    <= sclk_n;
      cs      <= cs_n;
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed and randomized bench for spi_master_core; expectations come from
// transfer-level rules (latency 17*div, SCLK period 2*div, MSB-first data).
module tb_spi_master_core;

  logic        clk = 1'b0;
  logic        reset, start, miso;
  logic [7:0]  tx_data, rx_data;
  logic [15:0] clk_div_in;
  logic        ready, busy, done, irq, mosi, sclk, cs;

  logic        loopback = 1'b1;
  logic [7:0]  slave_byte = '0;
  logic [2:0]  sidx = 3'd7;

  int n_assert = 0;
  int n_fail   = 0;

  spi_master_core #(.DEFAULT_CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
    .clk_div_in(clk_div_in), .rx_data(rx_data), .ready(ready), .busy(busy),
    .done(done), .irq(irq), .miso(miso), .mosi(mosi), .sclk(sclk), .cs(cs)
  );

  always #5 clk = ~clk;

  // Slave model: presents its byte MSB first, advancing after each falling SCLK.
  assign miso = loopback ? mosi : slave_byte[sidx];
  always @(negedge sclk) if (sidx != 3'd0) sidx = sidx - 3'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [15:0] dv, input logic lb,
                      input logic [7:0] sb, input bit hold, input bit poke,
                      input logic [7:0] next_tx, input logic [15:0] next_dv);
    int d, c, rises, last_rise, first_rise, done_cnt, done_at;
    logic [7:0] seen;
    bit per_ok, mosi_ok, rb_ok;
    logic ps, pm;
    d = (dv == 16'd0) ? 4 : int'(dv);
    loopback = lb; slave_byte = sb; sidx = 3'd7;
    tx_data = tx; clk_div_in = dv; start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    tx_data = 8'($urandom); clk_div_in = 16'($urandom);
    check("accept_cs", 32'(cs), 32'(1'b0));
    check("accept_busy", 32'(busy), 32'(1'b1));
    check("accept_irq", 32'(irq), 32'(1'b0));
    check("accept_mosi", 32'(mosi), 32'(tx[7]));
    c = 0; rises = 0; last_rise = 0; first_rise = -1; done_cnt = 0; done_at = -1;
    seen = '0; per_ok = 1; mosi_ok = 1; rb_ok = 1; ps = sclk; pm = mosi;
    while (done_at < 0 && c < 17 * d + 40) begin
      tick(); c++;
      if (sclk && !ps) begin
        rises++;
        seen = {seen[6:0], mosi};
        if (rises == 1) first_rise = c;
        else if (c - last_rise != 2 * d) per_ok = 0;
        last_rise = c;
      end
      if (mosi !== pm && !(ps && !sclk)) mosi_ok = 0;
      if (ready !== ~busy) rb_ok = 0;
      if (poke && c == 5 * d) begin start = 1'b1; tx_data = 8'h00; end
      if (poke && c == 5 * d + 1) start = 1'b0;
      if (done) begin done_cnt++; done_at = c; end
      ps = sclk; pm = mosi;
    end
    if (hold) begin
      tx_data = next_tx; clk_div_in = next_dv;
    end else begin
      repeat (3) begin tick(); if (done) done_cnt++; end
      check("idle_cs", 32'(cs), 32'(1'b1));
      check("idle_ready", 32'(ready), 32'(1'b1));
    end
    check("done_latency", 32'(done_at), 32'(17 * d));
    check("done_count", 32'(done_cnt), 32'(1));
    check("sclk_rises", 32'(rises), 32'(8));
    check("first_rise", 32'(first_rise), 32'(d));
    check("sclk_period", 32'(per_ok), 32'(1));
    check("mosi_edges", 32'(mosi_ok), 32'(1));
    check("ready_not_busy", 32'(rb_ok), 32'(1));
    check("mosi_bits", 32'(seen), 32'(tx));
    check("rx_data", 32'(rx_data), 32'(lb ? tx : sb));
    check("irq_set", 32'(irq), 32'(1'b1));
  endtask

  initial begin
    int c, rises, d2;
    logic ps;
    bit quiet;
    reset = 1'b0; start = 1'b0; tx_data = '0; clk_div_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_cs", 32'(cs), 32'(1'b1));
    check("rst_sclk", 32'(sclk), 32'(1'b0));
    check("rst_mosi", 32'(mosi), 32'(1'b0));
    check("rst_ready", 32'(ready), 32'(1'b1));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_done", 32'(done), 32'(1'b0));
    check("rst_irq", 32'(irq), 32'(1'b0));
    check("rst_rx", 32'(rx_data), 32'(8'h00));
    tick();

    xfer(8'hA5, 16'd0, 1'b1, 8'h00, 0, 0, 8'h00, 16'd0);
    repeat (5) tick();
    xfer(8'h3C, 16'd0, 1'b1, 8'h00, 0, 0, 8'h00, 16'd0);
    xfer(8'h5A, 16'd1, 1'b0, 8'hFF, 0, 0, 8'h00, 16'd0);
    xfer(8'h96, 16'd0, 1'b1, 8'h00, 0, 0, 8'h00, 16'd0);
    xfer(8'hA5, 16'd0, 1'b1, 8'h00, 0, 1, 8'h00, 16'd0);

    // Start held through completion: the next transfer begins right after done.
    xfer(8'hC3, 16'd2, 1'b1, 8'h00, 1, 0, 8'h5E, 16'd3);
    tick();
    start = 1'b0;
    check("hold_cs", 32'(cs), 32'(1'b0));
    check("hold_busy", 32'(busy), 32'(1'b1));
    check("hold_irq", 32'(irq), 32'(1'b0));
    check("hold_mosi", 32'(mosi), 32'(1'b0));
    c = 0;
    while (!done && c < 17 * 3 + 40) begin tick(); c++; end
    check("hold_latency", 32'(c), 32'(17 * 3));
    check("hold_rx", 32'(rx_data), 32'(8'h5E));
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      logic [7:0] t, s;
      logic [15:0] dv;
      logic lb;
      t = 8'($urandom); s = 8'($urandom);
      dv = 16'($urandom_range(0, 5)); lb = 1'($urandom_range(0, 1));
      xfer(t, dv, lb, s, 0, 0, 8'h00, 16'd0);
    end

    // Reset after the third SCLK rise aborts the transfer without completion.
    loopback = 1'b1; tx_data = 8'hA5; clk_div_in = '0; start = 1'b1;
    tick();
    start = 1'b0;
    c = 0; rises = 0; ps = sclk;
    while (rises < 3 && c < 200) begin
      tick(); c++;
      if (sclk && !ps) rises++;
      ps = sclk;
    end
    check("abort_rises", 32'(rises), 32'(3));
    reset = 1'b0;
    tick();
    check("abort_cs", 32'(cs), 32'(1'b1));
    check("abort_sclk", 32'(sclk), 32'(1'b0));
    check("abort_busy", 32'(busy), 32'(1'b0));
    check("abort_ready", 32'(ready), 32'(1'b1));
    check("abort_rx", 32'(rx_data), 32'(8'h00));
    reset = 1'b1;
    quiet = 1;
    d2 = 0;
    repeat (100) begin
      tick();
      if (done || irq || !cs) quiet = 0;
      d2++;
    end
    check("abort_quiet", 32'(quiet), 32'(1));
    check("abort_irq", 32'(irq), 32'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
